// File: rtl/cpu_pkg.sv
// Shared definitions for the processor front end: opcode encoding, sequencer states
// and the opcode field position inside an instruction word.
package cpu_pkg;

  localparam int OPC_MSB = 8;
  localparam int OPC_LSB = 6;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_HALT = 3'b111
  } opcode_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_REQ     = 4'd1,
    S_CAP     = 4'd2,
    S_SETTLE  = 4'd3,
    S_RUN     = 4'd4,
    S_WAIT    = 4'd5,
    S_IMM_REQ = 4'd6,
    S_IMM_CAP = 4'd7,
    S_IMM_RUN = 4'd8,
    S_HALT    = 4'd9
  } seq_state_t;

  // Opcodes 000..011 are executable; everything with the MSB set stops the sequencer.
  function automatic logic is_exec_op(input logic [2:0] opc);
    return (opc[2] == 1'b0);
  endfunction

endpackage

// File: rtl/prog_sequencer_done_watchdog.sv
// Loadable down-counter guarding the wait for the control FSM's done strobe.
// expired_o is raised on the last permitted waiting cycle.
module done_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Loaded with TIMEOUT-1 so that exactly TIMEOUT enabled cycles elapse before expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(TIMEOUT - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/prog_sequencer.sv
// Instruction sequencer: fetches words from a synchronous program ROM, launches each one
// on the control FSM with a run pulse and waits for done, handling MVI immediates.
import cpu_pkg::*;

module prog_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 9,
  parameter int PROG_LEN = 32,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] din_o,
  output logic              run_o,
  input  logic              done_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              err_o,
  output logic [7:0]        instr_cnt_o
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  seq_state_t        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0] din_q;
  logic              run_q;
  logic              busy_q;
  logic              halted_q;
  logic              err_q;
  logic [7:0]        instr_cnt_q;

  logic [2:0] opc_s;
  logic       wd_load_s;
  logic       wd_en_s;
  logic       wd_clr_s;
  logic       wd_expired_s;

  assign opc_s     = din_q[OPC_MSB:OPC_LSB];
  assign wd_load_s = (state_q == S_RUN) || (state_q == S_IMM_RUN);
  assign wd_en_s   = (state_q == S_WAIT);
  assign wd_clr_s  = start_i && ((state_q == S_IDLE) || (state_q == S_HALT));

  done_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr_s),
    .load_i    (wd_load_s),
    .en_i      (wd_en_s),
    .expired_o (wd_expired_s)
  );

  // Sequencer FSM; every output is a register updated alongside the state transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      rom_addr_q  <= '0;
      din_q       <= '0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      instr_cnt_q <= 8'd0;
    end else begin
      run_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            pc_q        <= '0;
            rom_addr_q  <= '0;
            err_q       <= 1'b0;
            instr_cnt_q <= 8'd0;
            busy_q      <= 1'b1;
            halted_q    <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        S_REQ: state_q <= S_CAP;
        S_CAP: begin
          din_q   <= rom_data_i;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (is_exec_op(opc_s)) begin
            run_q   <= 1'b1;
            state_q <= S_RUN;
          end else begin
            err_q    <= err_q | (opc_s != OP_HALT);
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end
        end
        S_RUN: begin
          if (opc_s == OP_MVI) begin
            rom_addr_q <= pc_q + ADDR_W'(1);
            state_q    <= S_IMM_REQ;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_IMM_REQ: begin
          if (pc_q == LAST_PC) begin
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= S_IMM_CAP;
          end
        end
        S_IMM_CAP: begin
          din_q   <= rom_data_i;
          run_q   <= 1'b1;
          state_q <= S_IMM_RUN;
        end
        S_IMM_RUN: state_q <= S_WAIT;
        // done wins over a same-cycle watchdog expiry.
        S_WAIT: begin
          if (done_i) begin
            if (instr_cnt_q != 8'hFF) begin
              instr_cnt_q <= instr_cnt_q + 8'd1;
            end
            if (pc_q == LAST_PC) begin
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              pc_q       <= pc_q + ADDR_W'(1);
              rom_addr_q <= pc_q + ADDR_W'(1);
              state_q    <= S_REQ;
            end
          end else if (wd_expired_s) begin
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end
        end
        default: begin
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign din_o       = din_q;
  assign run_o       = run_q;
  assign busy_o      = busy_q;
  assign halted_o    = halted_q;
  assign err_o       = err_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed programs plus random ROM images,
// each compared against an instruction-level timing model of the sequencer.
module tb_prog_sequencer;

  localparam int AW = 5;
  localparam int DW = 9;
  localparam int PL = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          done_i;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic [DW-1:0] din_o;
  logic          run_o;
  logic          busy_o;
  logic          halted_o;
  logic          err_o;
  logic [7:0]    instr_cnt_o;

  logic [DW-1:0] rom [PL];

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int done_at  = -1;
  int lat      = 1;
  bit imm_pend = 1'b0;
  bit prev_run = 1'b0;
  logic [DW-1:0] last_din;

  int            obs_cyc[$];
  logic [DW-1:0] obs_din[$];
  int            exp_cyc[$];
  logic [DW-1:0] exp_din[$];
  int            exp_cnt;
  int            exp_halt;
  bit            exp_err;

  prog_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PROG_LEN(PL), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .din_o       (din_o),
    .run_o       (run_o),
    .done_i      (done_i),
    .busy_o      (busy_o),
    .halted_o    (halted_o),
    .err_o       (err_o),
    .instr_cnt_o (instr_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1ns after the edge, then play the control FSM (done after the
  // last run of an instruction, lat cycles later; lat==0 means never).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    done_i = 1'b0;
    if (run_o) begin
      check_val("run_single_cycle", 32'(prev_run), 32'd0);
      obs_cyc.push_back(cyc);
      obs_din.push_back(din_o);
      last_din = din_o;
      if (!imm_pend && din_o[8:6] == 3'b001) begin
        imm_pend = 1'b1;
      end else begin
        imm_pend = 1'b0;
        if (lat > 0) done_at = cyc + lat;
      end
    end
    prev_run = run_o;
    if (cyc == done_at) begin
      done_i = 1'b1;
      check_val("din_held_at_done", 32'(din_o), 32'(last_din));
    end
  endtask

  // Instruction-level model: SETTLE at s, run at s+1, MVI immediate run at s+4,
  // next SETTLE 3 cycles after done, halt one cycle after the deciding event.
  task automatic build_model(input int c0);
    int pc = 0;
    int s  = c0 + 3;
    int last_run;
    int cnt = 0;
    logic [DW-1:0] w;
    exp_cyc.delete();
    exp_din.delete();
    exp_err  = 1'b0;
    exp_halt = -1;
    for (int guard = 0; guard < 2 * PL; guard++) begin
      w = rom[5'(pc)];
      if (w[8]) begin
        exp_err  = (w[8:6] != 3'b111);
        exp_halt = s + 1;
        break;
      end
      exp_cyc.push_back(s + 1);
      exp_din.push_back(w);
      last_run = s + 1;
      if (w[8:6] == 3'b001) begin
        if (pc == PL - 1) begin
          exp_err  = 1'b1;
          exp_halt = s + 3;
          break;
        end
        pc++;
        exp_cyc.push_back(s + 4);
        exp_din.push_back(rom[5'(pc)]);
        last_run = s + 4;
      end
      if (lat == 0) begin
        exp_err  = 1'b1;
        exp_halt = last_run + TO + 1;
        break;
      end
      if (cnt < 255) cnt++;
      if (pc == PL - 1) begin
        exp_halt = last_run + lat + 1;
        break;
      end
      pc++;
      s = last_run + lat + 3;
    end
    exp_cnt = cnt;
  endtask

  task automatic run_program(input string name, input int l, input bit dup_start);
    int c0;
    int n;
    lat      = l;
    imm_pend = 1'b0;
    done_at  = -1;
    obs_cyc.delete();
    obs_din.delete();
    c0 = cyc;
    build_model(c0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_val({name, "/rom_addr_restart"}, 32'(rom_addr_o), 32'd0);
    check_val({name, "/busy_after_start"}, 32'(busy_o), 32'd1);
    for (int i = 0; i < 2000 && !halted_o; i++) begin
      start_i = (dup_start && cyc == c0 + 2) ? 1'b1 : 1'b0;
      tick();
    end
    start_i = 1'b0;
    check_val({name, "/halted"}, 32'(halted_o), 32'd1);
    check_val({name, "/halt_cycle"}, 32'(cyc - c0), 32'(exp_halt - c0));
    check_val({name, "/run_count"}, 32'(obs_cyc.size()), 32'(exp_cyc.size()));
    n = (obs_cyc.size() < exp_cyc.size()) ? obs_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check_val({name, "/run_cycle"}, 32'(obs_cyc[i] - c0), 32'(exp_cyc[i] - c0));
      check_val({name, "/run_din"}, 32'(obs_din[i]), 32'(exp_din[i]));
    end
    check_val({name, "/instr_cnt"}, 32'(instr_cnt_o), 32'(exp_cnt));
    check_val({name, "/err"}, 32'(err_o), 32'(exp_err));
    check_val({name, "/busy_at_halt"}, 32'(busy_o), 32'd0);
    tick();
  endtask

  task automatic fill_rom(input logic [DW-1:0] w);
    for (int i = 0; i < PL; i++) rom[i] = w;
  endtask

  task automatic check_all_zero(input string name);
    check_val({name, "/rom_addr"}, 32'(rom_addr_o), 32'd0);
    check_val({name, "/din"}, 32'(din_o), 32'd0);
    check_val({name, "/run"}, 32'(run_o), 32'd0);
    check_val({name, "/busy"}, 32'(busy_o), 32'd0);
    check_val({name, "/halted"}, 32'(halted_o), 32'd0);
    check_val({name, "/err"}, 32'(err_o), 32'd0);
    check_val({name, "/instr_cnt"}, 32'(instr_cnt_o), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] w;
    int l;
    rst     = 1'b1;
    start_i = 1'b0;
    done_i  = 1'b0;
    fill_rom(9'h1C0);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    fill_rom(9'h1C0);
    rom[0] = 9'b000_001_010;
    run_program("mv_halt", 1, 1'b0);

    fill_rom(9'h1C0);
    rom[0] = 9'b001_011_000;
    rom[1] = 9'h055;
    run_program("mvi_halt", 1, 1'b0);

    fill_rom(9'h1C0);
    rom[0] = 9'b010_001_010;
    rom[1] = 9'b011_010_001;
    run_program("add_sub", 3, 1'b0);

    fill_rom(9'h1C0);
    rom[0] = 9'b100_000_000;
    run_program("illegal", 1, 1'b0);
    rom[0] = 9'b000_001_010;
    run_program("restart_clears_err", 1, 1'b0);

    run_program("done_timeout", 0, 1'b0);

    fill_rom(9'b000_010_011);
    run_program("end_of_rom", 1, 1'b0);
    rom[PL-1] = 9'b001_000_001;
    run_program("mvi_at_last", 2, 1'b0);

    // Asynchronous reset while waiting for done of an MVI immediate.
    fill_rom(9'h1C0);
    rom[0] = 9'b010_001_001;
    rom[1] = 9'b010_001_010;
    rom[2] = 9'b001_011_000;
    rom[3] = 9'h0AA;
    lat = 3;
    imm_pend = 1'b0;
    done_at = -1;
    obs_cyc.delete();
    obs_din.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 200 && obs_cyc.size() < 4; i++) tick();
    check_val("rst_mid/reached_imm_run", 32'(obs_cyc.size()), 32'd4);
    tick();
    check_val("rst_mid/pre_cnt", 32'(instr_cnt_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    done_at = -1;
    imm_pend = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    obs_cyc.delete();
    for (int i = 0; i < 12; i++) tick();
    check_val("rst_mid/no_run_without_start", 32'(obs_cyc.size()), 32'd0);
    check_val("rst_mid/idle_busy", 32'(busy_o), 32'd0);
    run_program("start_while_busy", 2, 1'b1);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < PL; i++) begin
        w = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 99) < 88) w[8] = 1'b0;
        rom[i] = w;
      end
      l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      run_program("random", l, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
